// File: rtl/serializador_registro_pkg.sv
// Shared definitions for the LSB-first word serializer: state encoding and default width.
package serializador_registro_pkg;

    localparam int STATE_W   = 2;
    localparam int N_DEFAULT = 4;

    typedef enum logic [STATE_W-1:0] {
        OCIOSO    = 2'd0,
        TRANSMITE = 2'd1,
        PARIDADE  = 2'd2,
        FIM       = 2'd3
    } estado_t;

endpackage

// File: rtl/serializador_registro_if.sv
// Handshake bundle between the control unit / consumer and the serializer.
// Handshake: a bit transfers on a rising edge where valido=1 and aceito=1; saida_serial is stable while valido=1 and aceito=0.
interface serializador_registro_if
    import serializador_registro_pkg::*;
#(
    parameter int N = N_DEFAULT
) ();
    localparam int CW = $clog2(N);

    logic          partida;
    logic [N-1:0]  D;
    logic          aceito;
    logic          saida_serial;
    logic          valido;
    logic          ocupado;
    logic          pronto;
    logic [CW-1:0] bits_enviados;
    estado_t       estado;

    modport master (
        output partida, D, aceito,
        input  saida_serial, valido, ocupado, pronto, bits_enviados, estado
    );

    modport slave (
        input  partida, D, aceito,
        output saida_serial, valido, ocupado, pronto, bits_enviados, estado
    );

endinterface

// File: rtl/serializador_registro_contador_bits.sv
// Bit counter for the serializer: async clear, synchronous zero, enable, end flag at N-1.
module contador_bits #(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          zera,
    input  logic          en,
    output logic [CW-1:0] q,
    output logic          fim
);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            q <= '0;
        end else if (zera) begin
            q <= '0;
        end else if (en) begin
            q <= q + 1'b1;
        end
    end

    assign fim = (q == CW'(N - 1));

endmodule

// File: rtl/serializador_registro.sv
// Captures an N-bit word on partida and shifts it out LSB-first over a valid/accept handshake.
// Optional even-parity trailer bit is enabled by defining SERIALIZADOR_PARIDADE_EN.
module serializador_registro
    import serializador_registro_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input logic                   clock,
    input logic                   clear,
    serializador_registro_if.slave bus
);
    localparam int CW = $clog2(N);

    estado_t       estado, proximo;
    logic [N-1:0]  registro;
    logic [CW-1:0] contagem;
    logic          ultimo;
    logic          captura;
    logic          aceita_bit;
    logic          saida;
    logic          valido;
    logic          ocupado;
    logic          pronto;
`ifdef SERIALIZADOR_PARIDADE_EN
    logic          paridade;
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo    = estado;
        captura    = 1'b0;
        aceita_bit = 1'b0;
        saida      = 1'b0;
        valido     = 1'b0;
        ocupado    = 1'b0;
        pronto     = 1'b0;
        case (estado)
            OCIOSO: begin
                if (bus.partida) begin
                    captura = 1'b1;
                    proximo = TRANSMITE;
                end
            end
            TRANSMITE: begin
                valido  = 1'b1;
                ocupado = 1'b1;
                saida   = registro[0];
                if (bus.aceito) begin
                    aceita_bit = 1'b1;
                    if (ultimo) begin
`ifdef SERIALIZADOR_PARIDADE_EN
                        proximo = PARIDADE;
`else
                        proximo = FIM;
`endif
                    end
                end
            end
`ifdef SERIALIZADOR_PARIDADE_EN
            PARIDADE: begin
                valido  = 1'b1;
                ocupado = 1'b1;
                saida   = paridade;
                if (bus.aceito) begin
                    proximo = FIM;
                end
            end
`endif
            FIM: begin
                pronto  = 1'b1;
                proximo = OCIOSO;
            end
            default: begin
                proximo = OCIOSO;
            end
        endcase
    end

    // The counter stops at N-1 so bits_enviados never wraps on the final acceptance.
    contador_bits #(
        .N  (N),
        .CW (CW)
    ) u_contador (
        .clock (clock),
        .clear (clear),
        .zera  (captura),
        .en    (aceita_bit && !ultimo),
        .q     (contagem),
        .fim   (ultimo)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            registro <= '0;
        end else if (captura) begin
            registro <= bus.D;
        end else if (aceita_bit) begin
            registro <= {1'b0, registro[N-1:1]};
        end
    end

`ifdef SERIALIZADOR_PARIDADE_EN
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            paridade <= 1'b0;
        end else if (captura) begin
            paridade <= ^bus.D;
        end
    end
`endif

    assign bus.saida_serial  = saida;
    assign bus.valido        = valido;
    assign bus.ocupado       = ocupado;
    assign bus.pronto        = pronto;
    assign bus.bits_enviados = contagem;
    assign bus.estado        = estado;

endmodule

// File: tb/tb_serializador_registro.sv
// Bench for serializador_registro: directed test-plan sequences plus random traffic against a word-level model.
module tb_serializador_registro;
    import serializador_registro_pkg::*;

    localparam int N  = 4;
    localparam int CW = $clog2(N);
`ifdef SERIALIZADOR_PARIDADE_EN
    localparam int TRANSF = N + 1;
`else
    localparam int TRANSF = N;
`endif

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    serializador_registro_if #(.N(N)) bus ();

    serializador_registro #(.N(N)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [0:0] exp_q[$];

    int m_rem    = 0;
    int m_cnt    = 0;
    bit m_fim    = 1'b0;
    int palavras = 0;
    int prontos  = 0;

    logic prev_valido = 1'b0;
    logic prev_aceito = 1'b0;
    logic prev_bit    = 1'b0;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
        end
    endtask

    // ---------------- reference model (word level) ----------------
    always @(posedge clock) begin
        if (clear) begin
            if (m_rem > 0) palavras--;
            m_rem = 0;
            m_cnt = 0;
            m_fim = 1'b0;
            exp_q.delete();
        end else if (m_fim) begin
            m_fim = 1'b0;
        end else if (m_rem > 0) begin
            if (bus.aceito) begin
                m_rem--;
                if (m_cnt < N - 1) m_cnt++;
                if (m_rem == 0) m_fim = 1'b1;
            end
        end else if (bus.partida) begin
            for (int i = 0; i < N; i++) begin
                exp_q.push_back(1'((int'(bus.D) >> i) % 2));
            end
`ifdef SERIALIZADOR_PARIDADE_EN
            exp_q.push_back(1'($countones(bus.D) % 2));
`endif
            m_rem = TRANSF;
            m_cnt = 0;
            palavras++;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (clear) begin
            prev_valido = 1'b0;
            prev_aceito = 1'b0;
        end else begin
            check("valido",        bus.valido,        32'(m_rem > 0));
            check("ocupado",       bus.ocupado,       32'(m_rem > 0));
            check("pronto",        bus.pronto,        32'(m_fim));
            check("bits_enviados", bus.bits_enviados, 32'(m_cnt));
            if (bus.pronto === 1'b1) prontos++;
            if (bus.valido && prev_valido && !prev_aceito) begin
                check("stall_stable", bus.saida_serial, prev_bit);
            end
            if (bus.valido === 1'b1 && bus.aceito === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bit_unexpected: got %0d expected none at %0t", bus.saida_serial, $time);
                end else begin
                    check("saida_serial", bus.saida_serial, exp_q.pop_front());
                end
            end
            prev_valido = bus.valido;
            prev_aceito = bus.aceito;
            prev_bit    = bus.saida_serial;
        end
    end

    // ---------------- driver ----------------
    task automatic ciclo(input logic p, input logic [N-1:0] d, input logic a);
        bus.partida = p;
        bus.D       = d;
        bus.aceito  = a;
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.partida = 1'b0;
        bus.D       = '0;
        bus.aceito  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_saida",   bus.saida_serial,  0);
        check("reset_valido",  bus.valido,        0);
        check("reset_ocupado", bus.ocupado,       0);
        check("reset_pronto",  bus.pronto,        0);
        check("reset_bits",    bus.bits_enviados, 0);
        clear = 1'b0;
        ciclo(0, '0, 0);

        // word 1011 with continuous acceptance
        ciclo(1, 4'b1011, 1);
        repeat (6) ciclo(0, 4'b1011, 1);

        // three-cycle stall before bit 2
        ciclo(1, 4'b1011, 0);
        repeat (2) ciclo(0, 4'b1011, 1);
        repeat (3) ciclo(0, 4'b1011, 0);
        repeat (5) ciclo(0, 4'b1011, 1);

        // D and partida change during the transfer
        ciclo(1, 4'b1011, 1);
        ciclo(0, 4'b0000, 1);
        ciclo(1, 4'b0000, 1);
        repeat (5) ciclo(0, 4'b0000, 1);

        // clear after two accepted bits
        ciclo(1, 4'b1011, 1);
        repeat (2) ciclo(0, 4'b1011, 1);
        clear = 1'b1;
        #1;
        check("clr_saida",   bus.saida_serial,  0);
        check("clr_valido",  bus.valido,        0);
        check("clr_ocupado", bus.ocupado,       0);
        check("clr_pronto",  bus.pronto,        0);
        check("clr_bits",    bus.bits_enviados, 0);
        @(posedge clock);
        #1;
        clear = 1'b0;
        ciclo(1, 4'b0110, 1);
        repeat (6) ciclo(0, 4'b0110, 1);

        // back-to-back words with partida held high
        repeat (3 * (TRANSF + 2)) ciclo(1, N'($urandom_range(0, 15)), 1);
        repeat (TRANSF + 2) ciclo(0, '0, 1);

        // random traffic
        repeat (400) begin
            ciclo(($urandom_range(0, 3) == 0), N'($urandom_range(0, (1 << N) - 1)),
                  ($urandom_range(0, 9) < 7));
        end

        // drain with a bounded wait
        bus.partida = 1'b0;
        bus.aceito  = 1'b1;
        for (int k = 0; k < 50 && (m_rem > 0 || m_fim || exp_q.size() > 0); k++) begin
            @(posedge clock);
            #1;
        end
        repeat (2) ciclo(0, '0, 1);
        check("drain_queue_empty", 32'(exp_q.size()), 0);
        check("pronto_per_word",   32'(prontos),      32'(palavras));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
